// File: rtl/cnn_layer_accel_result_packer.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_result_packer
//
// Purpose:
//   Collects the accelerator's stream of signed 16-bit results and packs them
//   into 128-bit words of eight lanes for the downstream writer. A job covers
//   num_cols x num_rows x num_depth results, consumed in col-fastest order.
//   A word is emitted when lane 7 is filled or when a row ends, so every word
//   holds results from a single row. The final word of the job carries
//   out_last. Once that word has been transferred, done pulses for one cycle.
//
// Optional feature:
//   CNN_RESULT_PACKER_RELU_EN - when defined, negative results are clamped to
//   zero before packing. When undefined, results are packed unmodified.
//
// Ports:
//   clk_core       in   1    core clock, rising edge
//   rst            in   1    synchronous active-high reset
//   cfg_start      in   1    job start pulse (honoured only when idle)
//   cfg_num_cols   in   16   output columns per row
//   cfg_num_rows   in   16   output rows per depth slice
//   cfg_num_depth  in   16   output depth slices
//   busy           out  1    job in progress (PACK or DRAIN)
//   done           out  1    one-cycle pulse at job end
//   result_valid   in   1    result stream valid
//   result_accept  out  1    result stream accept
//   result_data    in   16   one signed result
//   out_valid      out  1    packed word valid
//   out_ready      in   1    downstream ready
//   out_data       out  128  eight packed lanes, lane L at [16L+15:16L]
//   out_keep       out  8    mask of written lanes
//   out_last       out  1    word holds the final result of the job
// ---------------------------------------------------------------------------
module cnn_layer_accel_result_packer (
  input  logic         clk_core,
  input  logic         rst,
  input  logic         cfg_start,
  input  logic [15:0]  cfg_num_cols,
  input  logic [15:0]  cfg_num_rows,
  input  logic [15:0]  cfg_num_depth,
  output logic         busy,
  output logic         done,
  input  logic         result_valid,
  output logic         result_accept,
  input  logic [15:0]  result_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [7:0]   out_keep,
  output logic         out_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_nextState;

  logic [15:0]  r_numCols;
  logic [15:0]  r_numRows;
  logic [15:0]  r_numDepth;
  logic [15:0]  r_col;
  logic [15:0]  r_row;
  logic [15:0]  r_depth;
  logic [2:0]   r_lane;
  logic [127:0] r_stage;

  logic         r_outValid;
  logic [127:0] r_outData;
  logic [7:0]   r_outKeep;
  logic         r_outLast;

  logic         w_dimZero;
  logic         w_lastCol;
  logic         w_lastRow;
  logic         w_lastDepth;
  logic         w_finalResult;
  logic         w_resultAccept;
  logic         w_consume;
  logic         w_emit;
  logic         w_outXfer;
  logic [15:0]  w_laneValue;
  logic [127:0] w_laneShifted;
  logic [127:0] w_word;
  logic [7:0]   w_keep;

  // A job with any zero dimension has no results at all. Accept is held low
  // for it, so the single PACK cycle before DONE cannot swallow a result.
  // The end-of-row/slice/job tests compare the counters against the latched
  // dimensions minus one, all in unsigned 16-bit arithmetic.
  assign w_dimZero     = (r_numCols == 16'd0) || (r_numRows == 16'd0) ||
                         (r_numDepth == 16'd0);
  assign w_lastCol     = (r_col   == (r_numCols  - 16'd1));
  assign w_lastRow     = (r_row   == (r_numRows  - 16'd1));
  assign w_lastDepth   = (r_depth == (r_numDepth - 16'd1));
  assign w_finalResult = w_lastCol && w_lastRow && w_lastDepth;

  // Results are taken only while packing and while no emitted word is stuck
  // waiting for downstream. A word that transfers this very cycle frees the
  // slot, so packing continues without a bubble.
  assign w_outXfer      = r_outValid && out_ready;
  assign w_resultAccept = (r_state == PACK) && !w_dimZero &&
                          !(r_outValid && !out_ready);
  assign w_consume      = result_valid && w_resultAccept;
  assign w_emit         = w_consume && ((r_lane == 3'd7) || w_lastCol);

`ifdef CNN_RESULT_PACKER_RELU_EN
  // The ReLU build clamps negative results to zero as they enter the lane.
  assign w_laneValue = result_data[15] ? 16'h0000 : result_data;
`else
  // Without ReLU, results are packed exactly as they arrive.
  assign w_laneValue = result_data;
`endif

  // The staging register only ever holds lanes below the current lane index,
  // because it is cleared on every emission. OR-ing in the shifted result
  // therefore gives the complete word, with unwritten lanes left at zero.
  assign w_laneShifted = {112'd0, w_laneValue} << {r_lane, 4'b0000};
  assign w_word        = r_stage | w_laneShifted;

  // The keep mask covers lanes 0 up to and including the lane being written.
  always_comb begin
    w_keep = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_keep[i] = (3'(i) <= r_lane);
    end
  end

  // Next-state logic. A start pulse is only looked at in IDLE, so a pulse
  // mid-job is ignored. Leaving DRAIN waits for the handshake on the last
  // word, so done never fires while the final word is still pending.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (cfg_start) begin
          w_nextState = PACK;
        end
      end
      PACK: begin
        if (w_dimZero) begin
          w_nextState = DONE;
        end else if (w_consume && w_finalResult) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (w_outXfer) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register. Reset abandons any job in flight.
  always_ff @(posedge clk_core) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Job configuration, position counters and lane staging.
  // A start pulse in IDLE latches the dimensions and rewinds everything.
  // Each consumed result moves the position forward: col first, then row at
  // the end of a row, then depth at the end of a slice. The lane index and
  // staging word clear whenever a word is emitted, so the next row always
  // starts in lane 0.
  always_ff @(posedge clk_core) begin
    if (rst) begin
      r_numCols  <= 16'd0;
      r_numRows  <= 16'd0;
      r_numDepth <= 16'd0;
      r_col      <= 16'd0;
      r_row      <= 16'd0;
      r_depth    <= 16'd0;
      r_lane     <= 3'd0;
      r_stage    <= 128'd0;
    end else if ((r_state == IDLE) && cfg_start) begin
      r_numCols  <= cfg_num_cols;
      r_numRows  <= cfg_num_rows;
      r_numDepth <= cfg_num_depth;
      r_col      <= 16'd0;
      r_row      <= 16'd0;
      r_depth    <= 16'd0;
      r_lane     <= 3'd0;
      r_stage    <= 128'd0;
    end else if (w_consume) begin
      if (w_lastCol) begin
        r_col <= 16'd0;
        if (w_lastRow) begin
          r_row   <= 16'd0;
          r_depth <= r_depth + 16'd1;
        end else begin
          r_row <= r_row + 16'd1;
        end
      end else begin
        r_col <= r_col + 16'd1;
      end
      if (w_emit) begin
        r_lane  <= 3'd0;
        r_stage <= 128'd0;
      end else begin
        r_lane  <= r_lane + 3'd1;
        r_stage <= w_word;
      end
    end
  end

  // Output word register.
  // An emission loads a fresh word, and it takes priority over clearing
  // valid: a transfer and an emission in the same cycle simply replace the
  // word. Otherwise the word holds until the downstream handshake. Reset
  // drops any pending word without it being transferred.
  always_ff @(posedge clk_core) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outData  <= 128'd0;
      r_outKeep  <= 8'h00;
      r_outLast  <= 1'b0;
    end else if (w_emit) begin
      r_outValid <= 1'b1;
      r_outData  <= w_word;
      r_outKeep  <= w_keep;
      r_outLast  <= w_finalResult;
    end else if (w_outXfer) begin
      r_outValid <= 1'b0;
    end
  end

  assign busy          = (r_state == PACK) || (r_state == DRAIN);
  assign done          = (r_state == DONE);
  assign result_accept = w_resultAccept;
  assign out_valid     = r_outValid;
  assign out_data      = r_outData;
  assign out_keep      = r_outKeep;
  assign out_last      = r_outLast;

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// ---------------------------------------------------------------------------
// tb_cnn_layer_accel_result_packer
//
// Purpose:
//   Runs a series of jobs through the result packer and checks its output
//   against a reference model of the packing rules. For each job, the model
//   takes the list of results, cuts every row into chunks of at most eight,
//   and expects one word per chunk, with out_last only on the final chunk.
//   If CNN_RESULT_PACKER_RELU_EN is defined, the model applies the ReLU clamp
//   as well.
// ---------------------------------------------------------------------------
module tb_cnn_layer_accel_result_packer;

  logic         clk_core = 1'b0;
  logic         rst;
  logic         cfg_start;
  logic [15:0]  cfg_num_cols;
  logic [15:0]  cfg_num_rows;
  logic [15:0]  cfg_num_depth;
  logic         busy;
  logic         done;
  logic         result_valid;
  logic         result_accept;
  logic [15:0]  result_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [7:0]   out_keep;
  logic         out_last;

  int testsRun    = 0;
  int testsFailed = 0;

  // Free-running core clock.
  always #5 clk_core = ~clk_core;

  cnn_layer_accel_result_packer dut (
    .clk_core      (clk_core),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_num_cols  (cfg_num_cols),
    .cfg_num_rows  (cfg_num_rows),
    .cfg_num_depth (cfg_num_depth),
    .busy          (busy),
    .done          (done),
    .result_valid  (result_valid),
    .result_accept (result_accept),
    .result_data   (result_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_keep      (out_keep),
    .out_last      (out_last)
  );

  // One comparison. It bumps the counters and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // The value a result should have once it sits in its lane.
  function automatic logic [15:0] refLane(input logic [15:0] v);
`ifdef CNN_RESULT_PACKER_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  // Runs one complete job.
  // mode selects the result values: 0 random, 1 the sequence 1,2,3..., and
  // 2 a constant 16'hFFF0. Results are offered with probability validPct.
  // out_ready is held low for the first holdCycles cycles, and after that it
  // is high with probability readyPct. Transfers are collected and compared
  // with the model word list once done has been seen. Along the way the task
  // checks that a stalled word stays stable and that accept is low while
  // the word is stalled.
  task automatic applyStimulus(input string name, input int cols, input int rows,
                               input int depth, input int mode, input int validPct,
                               input int readyPct, input int holdCycles);
    logic [15:0]  vals[$];
    logic [127:0] expData[$];
    logic [7:0]   expKeep[$];
    logic         expLast[$];
    logic [127:0] obsData[$];
    logic [7:0]   obsKeep[$];
    logic         obsLast[$];
    logic [127:0] heldData;
    logic [8:0]   heldKeepLast;
    logic         held;
    logic         gotDone;
    logic         sawAccept;
    logic         sawValid;
    int           n;
    int           k;
    int           idx;
    int           iter;
    int           chunk;
    logic [127:0] wData;
    logic [7:0]   wKeep;

    n = cols * rows * depth;
    for (int i = 0; i < n; i++) begin
      case (mode)
        1:       vals.push_back(16'(i + 1));
        2:       vals.push_back(16'hFFF0);
        default: vals.push_back(16'($urandom));
      endcase
    end

    k = 0;
    for (int d = 0; d < depth; d++) begin
      for (int r = 0; r < rows; r++) begin
        for (int c0 = 0; c0 < cols; c0 += 8) begin
          chunk = ((cols - c0) < 8) ? (cols - c0) : 8;
          wData = '0;
          wKeep = '0;
          for (int j = 0; j < chunk; j++) begin
            wData[16*j +: 16] = refLane(vals[k]);
            wKeep[j] = 1'b1;
            k++;
          end
          expData.push_back(wData);
          expKeep.push_back(wKeep);
          expLast.push_back((d == depth - 1) && (r == rows - 1) && (c0 + 8 >= cols));
        end
      end
    end

    @(negedge clk_core);
    cfg_start     = 1'b1;
    cfg_num_cols  = 16'(cols);
    cfg_num_rows  = 16'(rows);
    cfg_num_depth = 16'(depth);
    result_valid  = 1'b0;
    out_ready     = 1'b0;

    idx = 0; iter = 0; held = 1'b0; gotDone = 1'b0;
    sawAccept = 1'b0; sawValid = 1'b0;
    heldData = '0; heldKeepLast = '0;
    while (!gotDone && iter < 3000) begin
      @(negedge clk_core);
      iter++;
      if (done) begin
        gotDone = 1'b1;
        checkOutput({name, " busy_at_done"}, 128'(busy), 128'd0);
      end else begin
        cfg_start = (iter == 3);
        if (iter == 3) begin
          cfg_num_cols  = 16'($urandom);
          cfg_num_rows  = 16'($urandom);
          cfg_num_depth = 16'($urandom);
        end
        if (held) begin
          checkOutput({name, " hold_valid"}, 128'(out_valid), 128'd1);
          checkOutput({name, " hold_data"}, out_data, heldData);
          checkOutput({name, " hold_keep_last"}, 128'({out_keep, out_last}),
                      128'(heldKeepLast));
        end
        result_valid = (idx < n) && ($urandom_range(99) < validPct);
        result_data  = (idx < n) ? vals[idx] : 16'($urandom);
        out_ready    = (iter > holdCycles) && ($urandom_range(99) < readyPct);
        #1;
        if (out_valid && !out_ready) begin
          checkOutput({name, " accept_stalled"}, 128'(result_accept), 128'd0);
        end
        if (out_valid) sawValid = 1'b1;
        if (result_accept) sawAccept = 1'b1;
        if (out_valid && out_ready) begin
          obsData.push_back(out_data);
          obsKeep.push_back(out_keep);
          obsLast.push_back(out_last);
        end
        if (result_valid && result_accept) idx++;
        held         = out_valid && !out_ready;
        heldData     = out_data;
        heldKeepLast = {out_keep, out_last};
      end
    end
    cfg_start    = 1'b0;
    result_valid = 1'b0;
    out_ready    = 1'b0;

    if (!gotDone) begin
      checkOutput({name, " timeout_waiting_done"}, 128'd0, 128'd1);
    end
    checkOutput({name, " results_consumed"}, 128'(idx), 128'(n));
    checkOutput({name, " word_count"}, 128'(obsData.size()), 128'(expData.size()));
    for (int i = 0; i < obsData.size() && i < expData.size(); i++) begin
      checkOutput($sformatf("%s w%0d data", name, i), obsData[i], expData[i]);
      checkOutput($sformatf("%s w%0d keep", name, i), 128'(obsKeep[i]), 128'(expKeep[i]));
      checkOutput($sformatf("%s w%0d last", name, i), 128'(obsLast[i]), 128'(expLast[i]));
    end
    if (n == 0) begin
      checkOutput({name, " zero_done_cycle"}, 128'(iter), 128'd2);
      checkOutput({name, " zero_no_accept"}, 128'(sawAccept), 128'd0);
      checkOutput({name, " zero_no_valid"}, 128'(sawValid), 128'd0);
    end

    @(negedge clk_core);
    checkOutput({name, " after_done_idle"}, 128'({done, busy}), 128'd0);
  endtask

  // Checks that every output is back at its reset value.
  task automatic checkResetOutputs(input string name);
    checkOutput({name, " ctrl_zero"},
                128'({busy, done, result_accept, out_valid, out_last}), 128'd0);
    checkOutput({name, " data_zero"}, out_data, 128'd0);
    checkOutput({name, " keep_zero"}, 128'(out_keep), 128'd0);
  endtask

  // Directed job sequence, followed by a batch of randomized jobs.
  initial begin
    rst           = 1'b1;
    cfg_start     = 1'b0;
    cfg_num_cols  = 16'd0;
    cfg_num_rows  = 16'd0;
    cfg_num_depth = 16'd0;
    result_valid  = 1'b0;
    result_data   = 16'd0;
    out_ready     = 1'b0;
    repeat (3) @(negedge clk_core);
    checkResetOutputs("reset");
    rst = 1'b0;

    applyStimulus("seq8", 8, 1, 1, 1, 100, 100, 0);
    applyStimulus("c10r2", 10, 2, 1, 0, 100, 100, 0);
    applyStimulus("stall16", 16, 1, 1, 0, 100, 100, 25);
    applyStimulus("cols0", 0, 3, 2, 0, 100, 100, 0);
    applyStimulus("depth0", 5, 2, 0, 0, 100, 100, 0);
    applyStimulus("relu", 3, 1, 1, 2, 100, 100, 0);

    // Abandon a job mid-flight while a word is pending downstream.
    @(negedge clk_core);
    cfg_start     = 1'b1;
    cfg_num_cols  = 16'd3;
    cfg_num_rows  = 16'd4;
    cfg_num_depth = 16'd1;
    out_ready     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_core);
      cfg_start    = 1'b0;
      result_valid = 1'b1;
      result_data  = 16'(16'h0100 + i);
    end
    @(negedge clk_core);
    result_valid = 1'b0;
    checkOutput("midreset pending_word", 128'(out_valid), 128'd1);
    rst = 1'b1;
    @(negedge clk_core);
    checkResetOutputs("midreset");
    rst = 1'b0;
    applyStimulus("after_reset", 8, 1, 1, 1, 100, 100, 0);

    for (int j = 0; j < 6; j++) begin
      applyStimulus($sformatf("rand%0d", j), int'($urandom_range(1, 20)),
                    int'($urandom_range(1, 3)), int'($urandom_range(1, 2)),
                    0, 70, 50, int'($urandom_range(0, 5)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
